// File: rtl/uart_rx_ovs.sv
// 16x-oversampled UART receiver, 5..9 data bits, optional parity, 1/2 stop bits; UART_RX_MAJORITY_EN selects 2-of-3 sampling.
// Frame appears 1 clk after the last stop-bit sample; held until out_ready, a frame completing onto an unaccepted one is dropped with overrun.
module uart_rx_ovs #(
  parameter int BAUD      = 9600,
  parameter int SYS_CLK   = 50_000_000,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_data,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_parity_err,
  output logic                 out_frame_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overrun,
  output logic                 busy
);

  localparam int DIV = SYS_CLK / (BAUD * 16);
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_M1   = CW'(DIV - 1);
  localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);

  if (DIV < 2) begin : g_div_check
    $error("uart_rx_ovs: SYS_CLK / (BAUD*16) must be at least 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                 state;
  logic                   sync1, sync2, sync3;
  logic [CW-1:0]          cnt;
  logic [3:0]             sub;
  logic [3:0]             bit_idx;
  logic                   stop_idx;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_err;
  logic                   fe_acc;
  logic                   tick, fall, smp_stb, smp, bit_end, last_stop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      sync3 <= 1'b1;
    end else begin
      sync1 <= in_data;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // sub counts ticks already seen in the bit, so "tick N" is the tick that moves sub to N.
  assign tick      = (cnt == DIV_M1);
  assign fall      = sync3 & ~sync2;
  assign bit_end   = tick && (sub == 4'd15);
  assign last_stop = (STOP_BITS == 1) || stop_idx;

`ifdef UART_RX_MAJORITY_EN
  logic maj7, maj8;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      maj7 <= 1'b1;
      maj8 <= 1'b1;
    end else begin
      if (tick && sub == 4'd6) maj7 <= sync2;
      if (tick && sub == 4'd7) maj8 <= sync2;
    end
  end

  assign smp_stb = tick && (sub == 4'd8);
  assign smp     = (maj7 & maj8) | (maj7 & sync2) | (maj8 & sync2);
`else
  assign smp_stb = tick && (sub == 4'd7);
  assign smp     = sync2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      cnt            <= '0;
      sub            <= '0;
      bit_idx        <= '0;
      stop_idx       <= 1'b0;
      shreg          <= '0;
      par_err        <= 1'b0;
      fe_acc         <= 1'b0;
      out_data       <= '0;
      out_parity_err <= 1'b0;
      out_frame_err  <= 1'b0;
      out_valid      <= 1'b0;
      overrun        <= 1'b0;
      busy           <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;

      if (state == S_IDLE) begin
        cnt <= '0;
        sub <= '0;
      end else begin
        cnt <= tick ? '0 : cnt + 1'b1;
        if (tick) sub <= sub + 4'd1;
      end

      case (state)
        S_IDLE: begin
          if (fall) begin
            state   <= S_START;
            busy    <= 1'b1;
            fe_acc  <= 1'b0;
            par_err <= 1'b0;
          end
        end
        S_START: begin
          if (smp_stb && smp) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (bit_end) begin
            state   <= S_DATA;
            bit_idx <= '0;
          end
        end
        S_DATA: begin
          if (smp_stb) shreg <= {smp, shreg[DATA_BITS-1:1]};
          if (bit_end) begin
            if (bit_idx == LAST_BIT) begin
              state    <= (PARITY != 0) ? S_PARITY : S_STOP;
              stop_idx <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end
        S_PARITY: begin
          if (smp_stb) par_err <= (PARITY == 1) ? ~(^shreg ^ smp) : (^shreg ^ smp);
          if (bit_end) begin
            state    <= S_STOP;
            stop_idx <= 1'b0;
          end
        end
        S_STOP: begin
          if (smp_stb) begin
            if (last_stop) begin
              // Leave at mid-bit so a back-to-back start edge is not missed.
              state <= S_IDLE;
              busy  <= 1'b0;
              if (!out_valid || out_ready) begin
                out_data       <= shreg;
                out_parity_err <= par_err;
                out_frame_err  <= fe_acc | ~smp;
                out_valid      <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              fe_acc <= fe_acc | ~smp;
            end
          end else if (bit_end) begin
            stop_idx <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Randomized self-checking bench for uart_rx_ovs: 8E1 instance plus a 7N2 instance.
module tb_uart_rx_ovs;
  localparam int SYS  = 50_000_000;
  localparam int BAUD = 115200;
  localparam int DIV  = 27;
  localparam int BIT  = 16 * DIV;
`ifdef UART_RX_MAJORITY_EN
  localparam int SMP_OFS = 9;
`else
  localparam int SMP_OFS = 8;
`endif

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       line_a = 1'b1, line_b = 1'b1, ready_a = 1'b1, ready_b = 1'b0;
  logic [7:0] da;
  logic [6:0] db;
  logic       pea, fea, va, ova, busya;
  logic       peb, feb, vb, ovb, busyb;

  uart_rx_ovs #(.BAUD(BAUD), .SYS_CLK(SYS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(line_a), .out_data(da), .out_parity_err(pea),
    .out_frame_err(fea), .out_valid(va), .out_ready(ready_a), .overrun(ova), .busy(busya));

  uart_rx_ovs #(.BAUD(BAUD), .SYS_CLK(SYS), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(line_b), .out_data(db), .out_parity_err(peb),
    .out_frame_err(feb), .out_valid(vb), .out_ready(ready_b), .overrun(ovb), .busy(busyb));

  always #10 clk = ~clk;

  typedef struct {logic [7:0] d; logic pe; logic fe; int t;} cap_t;
  cap_t capq[$];
  int   cyc = 0, ovr_cnt = 0, vld_cyc = 0, last_c0 = 0;
  int   checks = 0, failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (va && ready_a) capq.push_back('{da, pea, fea, cyc});
      if (ova) ovr_cnt++;
      if (va) vld_cyc++;
    end
  end

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog cycles=%0d limit=150000", cyc);
    $fatal(1, "watchdog");
  end

  task automatic set_line(input bit sel, input logic v);
    if (sel) line_b = v; else line_a = v;
  endtask

  // Serialise one frame; the line changes right after each falling clock edge.
  task automatic send_frame(input bit sel, input logic [8:0] d, input int nb, input int pm,
                            input bit pflip, input int ns, input logic [1:0] stopv, input int glitch);
    logic bits [0:12];
    logic x;
    int   n;
    bits[0] = 1'b0;
    x = 1'b0;
    for (int i = 0; i < nb; i++) begin
      bits[1+i] = d[i];
      x ^= d[i];
    end
    n = 1 + nb;
    if (pm != 0) begin
      bits[n] = ((pm == 1) ? ~x : x) ^ pflip;
      n++;
    end
    for (int s = 0; s < ns; s++) bits[n+s] = stopv[s];
    n += ns;
    @(negedge clk);
    last_c0 = cyc;
    for (int i = 0; i < n * BIT; i++) begin
      set_line(sel, (glitch > 0 && i == glitch) ? 1'b0 : bits[i/BIT]);
      @(negedge clk);
    end
    set_line(sel, 1'b1);
  endtask

  task automatic wait_cap(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < BIT; k++) begin
      if (capq.size() != 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (5) @(negedge clk);
    checks++; if (va !== 1'b0)   begin failures++; $display("FAIL reset_valid got=%b exp=0", va); end
    checks++; if (da !== 8'h00)  begin failures++; $display("FAIL reset_data got=%h exp=00", da); end
    checks++; if ({pea, fea, ova} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {pea, fea, ova}); end
    checks++; if (busya !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busya); end
    checks++; if (vb !== 1'b0)   begin failures++; $display("FAIL reset_valid_b got=%b exp=0", vb); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic();
    bit   ok;
    cap_t c;
    int   exp_t;
    ready_a = 1'b1;
    vld_cyc = 0;
    send_frame(1'b0, 9'h0A5, 8, 2, 1'b0, 1, 2'b11, 0);
    // start at 3 clk after line edge; last stop bit index 10 in an 8E1 frame
    exp_t = last_c0 + 3 + (16 * 10 + SMP_OFS) * DIV;
    wait_cap(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_timeout got=none exp=frame"); end
    else begin
      c = capq.pop_front();
      checks++; if (c.d !== 8'hA5) begin failures++; $display("FAIL basic_data got=%h exp=a5", c.d); end
      checks++; if ({c.pe, c.fe} !== 2'b00) begin failures++; $display("FAIL basic_flags got=%b exp=00", {c.pe, c.fe}); end
      checks++; if (c.t != exp_t) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", c.t, exp_t); end
    end
    repeat (4) @(negedge clk);
    checks++; if (vld_cyc != 1) begin failures++; $display("FAIL basic_valid_width got=%0d exp=1", vld_cyc); end
    checks++; if (busya !== 1'b0) begin failures++; $display("FAIL basic_busy got=%b exp=0", busya); end
  endtask

  task automatic test_errors();
    bit   ok;
    cap_t c;
    send_frame(1'b0, 9'h03C, 8, 2, 1'b1, 1, 2'b11, 0);
    wait_cap(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL perr_timeout got=none exp=frame"); end
    else begin
      c = capq.pop_front();
      checks++; if ({c.d, c.pe, c.fe} !== {8'h3C, 2'b10}) begin failures++; $display("FAIL perr_frame got=%h/%b%b exp=3c/10", c.d, c.pe, c.fe); end
    end
    send_frame(1'b0, 9'h000, 8, 2, 1'b0, 1, 2'b10, 0);
    wait_cap(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL ferr_timeout got=none exp=frame"); end
    else begin
      c = capq.pop_front();
      checks++; if ({c.d, c.pe, c.fe} !== {8'h00, 2'b01}) begin failures++; $display("FAIL ferr_frame got=%h/%b%b exp=00/01", c.d, c.pe, c.fe); end
    end
    repeat (BIT) @(negedge clk);
  endtask

  task automatic test_glitch();
    bit seen;
    seen = 1'b0;
    vld_cyc = 0;
    @(negedge clk);
    line_a = 1'b0;
    repeat (4 * DIV) begin
      @(negedge clk);
      seen |= busya;
    end
    line_a = 1'b1;
    repeat (2 * BIT) begin
      @(negedge clk);
      seen |= busya;
    end
    checks++; if (seen !== 1'b1) begin failures++; $display("FAIL glitch_busy_seen got=%b exp=1", seen); end
    checks++; if (busya !== 1'b0) begin failures++; $display("FAIL glitch_busy_end got=%b exp=0", busya); end
    checks++; if (vld_cyc != 0 || capq.size() != 0) begin failures++; $display("FAIL glitch_valid got=%0d exp=0", vld_cyc); end
  endtask

  task automatic test_overrun();
    ready_a = 1'b0;
    ovr_cnt = 0;
    send_frame(1'b0, 9'h011, 8, 2, 1'b0, 1, 2'b11, 0);
    send_frame(1'b0, 9'h022, 8, 2, 1'b0, 1, 2'b11, 0);
    checks++; if ({va, da} !== {1'b1, 8'h11}) begin failures++; $display("FAIL ovr_held got=%b/%h exp=1/11", va, da); end
    checks++; if (ovr_cnt != 1) begin failures++; $display("FAIL ovr_pulses got=%0d exp=1", ovr_cnt); end
    @(posedge clk); #1 ready_a = 1'b1;
    @(posedge clk); #1;
    checks++; if (va !== 1'b0) begin failures++; $display("FAIL ovr_drop_valid got=%b exp=0", va); end
    checks++;
    if (capq.size() != 1) begin failures++; $display("FAIL ovr_accept got=%0d frames exp=1", capq.size()); end
    else if (capq[0].d !== 8'h11) begin failures++; $display("FAIL ovr_accept got=%h exp=11", capq[0].d); end
    capq.delete();
  endtask

  task automatic test_random();
    bit         ok, pf;
    logic [7:0] d;
    logic [1:0] sv;
    cap_t       c;
    ready_a = 1'b1;
    for (int f = 0; f < 4; f++) begin
      d  = 8'($urandom_range(0, 255));
      pf = ($urandom_range(0, 2) == 0);
      sv = {1'b1, ($urandom_range(0, 3) != 0)};
      send_frame(1'b0, {1'b0, d}, 8, 2, pf, 1, sv, 0);
      wait_cap(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL rand%0d_timeout got=none exp=frame", f); end
      else begin
        c = capq.pop_front();
        if ({c.d, c.pe, c.fe} !== {d, pf, ~sv[0]}) begin
          failures++;
          $display("FAIL rand%0d got=%h/%b%b exp=%h/%b%b", f, c.d, c.pe, c.fe, d, pf, ~sv[0]);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    bit          ok;
    cap_t        c;
    logic [7:0]  d;
    ready_a = 1'b0;
    send_frame(1'b0, 9'h05A, 8, 2, 1'b0, 1, 2'b11, 0);
    checks++; if ({va, da} !== {1'b1, 8'h5A}) begin failures++; $display("FAIL mrst_held got=%b/%h exp=1/5a", va, da); end
    d = 8'hC3;
    @(negedge clk);
    line_a = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      line_a = d[i];
      repeat (BIT) @(negedge clk);
    end
    line_a = d[3];
    repeat (BIT / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if ({va, da, pea, fea, ova, busya} !== 13'h0) begin failures++; $display("FAIL mrst_outputs got=%b/%h/%b%b%b%b exp=0", va, da, pea, fea, ova, busya); end
    line_a = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ready_a = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    checks++; if (capq.size() != 0 || busya !== 1'b0) begin failures++; $display("FAIL mrst_partial got=%0d frames busy=%b exp=0", capq.size(), busya); end
    send_frame(1'b0, 9'h0F0, 8, 2, 1'b0, 1, 2'b11, 0);
    wait_cap(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL mrst_clean_timeout got=none exp=frame"); end
    else begin
      c = capq.pop_front();
      if ({c.d, c.pe, c.fe} !== {8'hF0, 2'b00}) begin failures++; $display("FAIL mrst_clean got=%h/%b%b exp=f0/00", c.d, c.pe, c.fe); end
    end
  endtask

  task automatic test_7n2();
    ready_b = 1'b0;
    send_frame(1'b1, 9'h055, 7, 0, 1'b0, 2, 2'b11, 0);
    checks++; if ({vb, db, peb, feb} !== {1'b1, 7'h55, 2'b00}) begin failures++; $display("FAIL b7n2_good got=%b/%h/%b%b exp=1/55/00", vb, db, peb, feb); end
    @(posedge clk); #1 ready_b = 1'b1;
    @(posedge clk); #1 ready_b = 1'b0;
    checks++; if (vb !== 1'b0) begin failures++; $display("FAIL b7n2_accept got=%b exp=0", vb); end
    send_frame(1'b1, 9'h055, 7, 0, 1'b0, 2, 2'b01, 0);
    checks++; if ({vb, db, peb, feb} !== {1'b1, 7'h55, 2'b01}) begin failures++; $display("FAIL b7n2_stop2 got=%b/%h/%b%b exp=1/55/01", vb, db, peb, feb); end
  endtask

`ifdef UART_RX_MAJORITY_EN
  task automatic test_majority();
    bit   ok;
    cap_t c;
    ready_a = 1'b1;
    // one-clk low in data bit 0, landing on the tick-8 sample of the synchronized line
    send_frame(1'b0, 9'h001, 8, 2, 1'b0, 1, 2'b11, BIT + 8 * DIV);
    wait_cap(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL maj_timeout got=none exp=frame"); end
    else begin
      c = capq.pop_front();
      if ({c.d, c.pe} !== {8'h01, 1'b0}) begin failures++; $display("FAIL maj_data got=%h/%b exp=01/0", c.d, c.pe); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_errors();
    test_glitch();
    test_overrun();
    test_random();
    test_mid_reset();
    test_7n2();
`ifdef UART_RX_MAJORITY_EN
    test_majority();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
